pool_stream_reader: RTL and testbench
=====================================

Name: pool_stream_reader

Overview:
- Read side of the conv result register file.
- After pooling finishes, walks the 14x14 pooled results left in place in each 28x28 channel bank (2x2 window top-left addresses) across all 8 output channels.
- Issues synchronous reads and emits the values as a valid/ready byte stream to the next layer (FC or next conv input buffer).
- Keeps full throughput with a 2-entry output buffer and in-flight read credit.

Parameters:
- IMG_W, 28, conv output row width in the bank (words).
- POOL_W, 14, pooled rows/cols per channel.
- NUM_CH, 8, output channels (banks).
- DATA_W, 8, data width (signed, passed through unmodified).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begins a full readout; ignored while busy.
- rd_en  output  1  read strobe to result memory.
- rd_c  output  4  bank/channel select for the read.
- rd_addr  output  10  word address within the bank.
- rd_data  input  DATA_W  read data, valid exactly 1 cycle after rd_en.
- out_valid  output  1  stream data valid.
- out_ready  input  1  downstream accept.
- out_data  output  DATA_W  pooled value.
- out_chan  output  4  channel of out_data.
- out_last  output  1  high with the final element of the readout.
- busy  output  1  readout in progress.
- done  output  1  one-cycle pulse after the last element is accepted.

Behaviour:
- Reset (rst low, async): all outputs 0, FSM IDLE, counters 0, buffer empty, in-flight cleared.
- FSM states: IDLE -> RUN on start. RUN -> DRAIN when the last read is issued. DRAIN -> DONE when the buffer is empty and the last element has been accepted. DONE -> IDLE after 1 cycle; done=1 only in DONE.
- busy=1 in RUN and DRAIN.
- Address generation: pooled (r,c), 0<=r,c<14, lives at addr = 2*IMG_W*r + 2*c = 56r + 2c. First = 0, last = 754. 196 elements per channel; 1568 total.
- Default order is channel-major: ch0 r0 c0..c13, r1 ..., then ch1 ... ch7. c wraps 13->0 with r+1; r wraps 13->0 with ch+1.
- Read credit: rd_en is asserted in RUN only when (buffer count + reads in flight) < 2. At most one read per cycle.
- rd_c and rd_addr are valid only while rd_en=1; otherwise they hold their last value.
- Data capture: rd_data is pushed into the 2-entry FIFO on the cycle after rd_en, together with its channel and last flag.
- Output: out_valid = FIFO non-empty; out_data/out_chan/out_last come from the FIFO head. Pop when out_valid && out_ready.
- Push and pop in the same cycle are both honoured and the count is unchanged.
- Output stability: while out_valid=1 and out_ready=0, out_data, out_chan and out_last are held stable.
- Throughput: with out_ready held high, one element per cycle after 2 cycles of latency from start. start at cycle 0 gives rd_en at cycle 1 and the first out_valid at cycle 2.
- Timing: first read issues the cycle after start. Last accepted element is followed by done on the next cycle.
- Boundaries:
  - start while busy: ignored.
  - start coinciding with done: ignored; a new start is accepted only in IDLE.
  - out_ready low indefinitely: no reads beyond credit; no data is lost or overwritten.
  - rst asserted mid-readout: immediate return to IDLE, FIFO flushed, no done pulse. The late rd_data from an in-flight read is discarded.
- No arithmetic on data; values are passed bit-exact (already ReLU-clamped upstream).

Optional Feature:
- Macro: POOL_STREAM_INTERLEAVE_EN.
- Defined: pixel-major order, i.e. for each (r,c), ch0..ch7 before advancing c (flatten order for the FC layer). Address sequence 0 (ch0..7), 2 (ch0..7), ..., 754 (ch0..7). out_last stays on element 1568 (ch7, addr 754).
- Undefined: channel-major order as above.
- Element count, handshake and timing are identical in both builds.

Test Plan:
- Reset: drive rst low mid-cycle -> all outputs 0 immediately; busy=0, done=0.
- Ordering, channel-major, out_ready=1: start -> rd_addr sequence 0,2,...,26,56,58,...,754 for rd_c=0, then rd_c=1 from 0. Exactly 1568 outputs; out_last only on element 1568 (chan 7); done 1 cycle later.
- Backpressure: hold out_ready=0 for 20 cycles after the first out_valid -> at most 2 reads issued and out_data stable. Then toggle out_ready 1/0 randomly -> output sequence equals the memory model sequence with no loss or duplicates.
- start while busy and at DONE: pulse start at element 100 and on the done cycle -> no restart. A start 1 cycle after done -> a fresh 1568-element readout.
- Reset mid-run: assert rst at element 500 while a read is in flight -> FIFO empty, out_valid=0, no done pulse. A subsequent start replays from ch0 addr 0.
- With POOL_STREAM_INTERLEAVE_EN: first 9 outputs are (ch0..ch7, addr 0) then (ch0, addr 2). The last output is ch7 addr 754 with out_last=1.

Source files
------------

// File: rtl/pool_stream_reader.sv
// pool_stream_reader: streams the 14x14 pooled results of all channel banks out as valid/ready bytes.
// Define POOL_STREAM_INTERLEAVE_EN for pixel-major (all channels per pixel) order instead of channel-major.
module pool_stream_reader #(
  parameter int IMG_W  = 28,
  parameter int POOL_W = 14,
  parameter int NUM_CH = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              rd_en,
  output logic [3:0]        rd_c,
  output logic [9:0]        rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [3:0]        out_chan,
  output logic              out_last,
  output logic              busy,
  output logic              done
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
  localparam logic [3:0] CH_MAX = 4'(NUM_CH - 1);
  localparam logic [3:0] P_MAX  = 4'(POOL_W - 1);
  localparam int EW = DATA_W + 5;
  state_t state, state_n;
  logic [3:0] ch, r, c, pend_c;
  logic pend_last, inflight, at_last, ch_step, r_step, c_step, credit, pop, wr, rd_ptr, wr_ptr;
  logic [1:0] count;
  logic [EW-1:0] mem [2];
  logic [EW-1:0] head;

  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= S_IDLE;
    else state <= state_n;

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  state_n = start ? S_RUN : S_IDLE;
      S_RUN:   state_n = (rd_en && at_last) ? S_DRAIN : S_RUN;
      S_DRAIN: state_n = (pop && out_last) ? S_DONE : S_DRAIN;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    busy  = state == S_RUN || state == S_DRAIN;
    done  = state == S_DONE;
    rd_en = state == S_RUN && credit;
  end

  assign credit  = ({1'b0, count} + {2'b0, inflight}) < 3'd2;
  assign at_last = ch == CH_MAX && r == P_MAX && c == P_MAX;
  assign rd_c    = ch;
  assign rd_addr = 10'(r) * 10'(2 * IMG_W) + 10'({c, 1'b0});

`ifdef POOL_STREAM_INTERLEAVE_EN
  assign ch_step = 1'b1;
  assign c_step  = ch == CH_MAX;
  assign r_step  = ch == CH_MAX && c == P_MAX;
`else
  assign c_step  = 1'b1;
  assign r_step  = c == P_MAX;
  assign ch_step = c == P_MAX && r == P_MAX;
`endif

  // counters park on the final position so rd_c/rd_addr hold after the last read
  always_ff @(posedge clk or negedge rst)
    if (!rst) {ch, r, c} <= '0;
    else if (state == S_IDLE && start) {ch, r, c} <= '0;
    else if (rd_en && !at_last) begin
      if (c_step) c <= (c == P_MAX) ? 4'd0 : c + 4'd1;
      if (r_step) r <= (r == P_MAX) ? 4'd0 : r + 4'd1;
      if (ch_step) ch <= (ch == CH_MAX) ? 4'd0 : ch + 4'd1;
    end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      inflight  <= 1'b0;
      pend_c    <= '0;
      pend_last <= 1'b0;
    end else begin
      inflight <= rd_en;
      if (rd_en) begin
        pend_c    <= ch;
        pend_last <= at_last;
      end
    end

  // returning read data falls through to the output when the buffer is empty
  assign head = (count != 2'd0) ? mem[rd_ptr] : inflight ? {rd_data, pend_c, pend_last} : '0;
  assign {out_data, out_chan, out_last} = head;
  assign out_valid = count != 2'd0 || inflight;
  assign pop = out_valid && out_ready;
  assign wr  = inflight && !(pop && count == 2'd0);

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (wr) begin
        mem[wr_ptr] <= {rd_data, pend_c, pend_last};
        wr_ptr      <= ~wr_ptr;
      end
      if (pop && count != 2'd0) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, inflight} - {1'b0, pop};
    end
endmodule

// File: tb/tb_pool_stream_reader.sv
// tb_pool_stream_reader: randomized-memory bench comparing the stream against an ordering model.
module tb_pool_stream_reader;
  localparam int N = 1568;
  logic clk = 0, rst = 0, start = 0, out_ready = 0;
  logic rd_en, out_valid, out_last, busy, done;
  logic [3:0] rd_c, out_chan;
  logic [9:0] rd_addr;
  logic [7:0] rd_data = 0, out_data;
  int compared = 0, mismatched = 0;
  logic [7:0] mem [8][1024];
  logic [13:0] exp_rd[$], rd_q[$];
  logic [12:0] exp_out[$], acc_q[$];
  int cyc = 0, s_cyc = 0, first_rd = -1, first_val = -1, last_acc = -1, done_cyc = -1, done_cnt = 0;

  pool_stream_reader dut (
    .clk(clk), .rst(rst), .start(start), .rd_en(rd_en), .rd_c(rd_c), .rd_addr(rd_addr),
    .rd_data(rd_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_chan(out_chan), .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    if (rd_en) rd_data <= mem[rd_c[2:0]][rd_addr];
  end

  always @(negedge clk)
    if (rst) begin
      if (rd_en) begin
        rd_q.push_back({rd_c, rd_addr});
        if (first_rd < 0) first_rd = cyc;
      end
      if (out_valid && first_val < 0) first_val = cyc;
      if (out_valid && out_ready) begin
        acc_q.push_back({out_chan, out_last, out_data});
        last_acc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end

  task automatic add_exp(input int ch, input int a);
    exp_rd.push_back({4'(ch), 10'(a)});
    exp_out.push_back({4'(ch), 1'(exp_out.size() == N - 1), mem[ch][a]});
  endtask

  task automatic build_model;
    for (int ch = 0; ch < 8; ch++)
      for (int a = 0; a < 1024; a++) mem[ch][a] = 8'($urandom);
`ifdef POOL_STREAM_INTERLEAVE_EN
    for (int r = 0; r < 14; r++) for (int c = 0; c < 14; c++) for (int ch = 0; ch < 8; ch++) add_exp(ch, 56 * r + 2 * c);
`else
    for (int ch = 0; ch < 8; ch++) for (int r = 0; r < 14; r++) for (int c = 0; c < 14; c++) add_exp(ch, 56 * r + 2 * c);
`endif
  endtask

  function automatic int diff_out();
    int n = acc_q.size() < exp_out.size() ? acc_q.size() : exp_out.size();
    for (int i = 0; i < n; i++) if (acc_q[i] !== exp_out[i]) return i;
    return (acc_q.size() == exp_out.size()) ? -1 : n;
  endfunction

  function automatic int diff_rd();
    int n = rd_q.size() < exp_rd.size() ? rd_q.size() : exp_rd.size();
    for (int i = 0; i < n; i++) if (rd_q[i] !== exp_rd[i]) return i;
    return (rd_q.size() == exp_rd.size()) ? -1 : n;
  endfunction

  task automatic nclk;
    @(negedge clk);
    #1;
  endtask

  task automatic clear_log;
    rd_q.delete();
    acc_q.delete();
    first_rd = -1; first_val = -1; last_acc = -1; done_cyc = -1; done_cnt = 0;
  endtask

  task automatic pulse_start;
    @(posedge clk);
    #1 start = 1;
    s_cyc = cyc;
    @(posedge clk);
    #1 start = 0;
  endtask

  task automatic wait_done(input int limit, output bit ok);
    ok = 0;
    for (int i = 0; i < limit; i++) begin
      nclk();
      if (done) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic check_run(input string tag, input bit ok);
    int d;
    compared++;
    if (!ok) begin mismatched++; $display("FAIL %s_done_timeout got no done pulse", tag); end
    d = diff_rd();
    compared++;
    if (d != -1) begin
      mismatched++;
      $display("FAIL %s_rd_seq idx %0d got %h want %h (count %0d want %0d)", tag, d, rd_q[d], exp_rd[d], rd_q.size(), exp_rd.size());
    end
    d = diff_out();
    compared++;
    if (d != -1) begin
      mismatched++;
      $display("FAIL %s_out_seq idx %0d got %h want %h (count %0d want %0d)", tag, d, acc_q[d], exp_out[d], acc_q.size(), exp_out.size());
    end
  endtask

  task automatic test_reset;
    #12;
    compared++;
    if ({rd_en, rd_c, rd_addr, out_valid, out_data, out_chan, out_last, busy, done} !== '0) begin
      mismatched++;
      $display("FAIL reset_outputs got %b want all zero", {rd_en, rd_c, rd_addr, out_valid, out_data, out_chan, out_last, busy, done});
    end
    @(posedge clk);
    #1 rst = 1;
  endtask

  task automatic test_order;
    bit ok;
    out_ready = 1;
    clear_log();
    pulse_start();
    wait_done(4000, ok);
    check_run("order", ok);
    compared++;
    if (first_rd != s_cyc + 1) begin mismatched++; $display("FAIL order_rd_latency got %0d want %0d", first_rd - s_cyc, 1); end
    compared++;
    if (first_val != s_cyc + 2) begin mismatched++; $display("FAIL order_valid_latency got %0d want %0d", first_val - s_cyc, 2); end
    compared++;
    if (done_cyc != last_acc + 1) begin mismatched++; $display("FAIL order_done_timing got %0d want %0d", done_cyc, last_acc + 1); end
    compared++;
    if (done_cyc != s_cyc + N + 2) begin mismatched++; $display("FAIL order_throughput got %0d cycles want %0d", done_cyc - s_cyc, N + 2); end
    nclk();
    compared++;
    if ({busy, done, done_cnt} !== {1'b0, 1'b0, 32'd1}) begin
      mismatched++;
      $display("FAIL order_after_done got busy=%b done=%b pulses=%0d want 0 0 1", busy, done, done_cnt);
    end
  endtask

  task automatic test_backpressure;
    bit ok, ps;
    int stable_err = 0;
    logic [12:0] pd;
    out_ready = 0;
    clear_log();
    pulse_start();
    for (int i = 0; i < 10 && !out_valid; i++) nclk();
    pd = {out_chan, out_last, out_data};
    for (int i = 0; i < 20; i++) begin
      nclk();
      if ({out_valid, out_chan, out_last, out_data} !== {1'b1, pd}) stable_err++;
    end
    compared++;
    if (stable_err != 0) begin mismatched++; $display("FAIL bp_hold_stable got %0d changes want 0", stable_err); end
    compared++;
    if (rd_q.size() != 2) begin mismatched++; $display("FAIL bp_read_credit got %0d reads want 2", rd_q.size()); end
    ps = 1;
    ok = 0;
    for (int i = 0; i < 20000; i++) begin
      @(posedge clk);
      #1 out_ready = 1'($urandom_range(0, 1));
      nclk();
      if (ps && {out_valid, out_chan, out_last, out_data} !== {1'b1, pd}) stable_err++;
      ps = out_valid && !out_ready;
      pd = {out_chan, out_last, out_data};
      if (done) begin
        ok = 1;
        break;
      end
    end
    check_run("bp", ok);
    compared++;
    if (stable_err != 0) begin mismatched++; $display("FAIL bp_random_stable got %0d changes want 0", stable_err); end
    compared++;
    if (done_cnt != 1) begin mismatched++; $display("FAIL bp_done_count got %0d want 1", done_cnt); end
    out_ready = 1;
  endtask

  task automatic test_start_ignore;
    bit ok;
    out_ready = 1;
    clear_log();
    pulse_start();
    for (int i = 0; i < 300 && acc_q.size() < 100; i++) nclk();
    start = 1;
    nclk();
    start = 0;
    wait_done(4000, ok);
    start = 1;
    @(posedge clk);
    #1 start = 0;
    repeat (5) nclk();
    check_run("ignore", ok);
    compared++;
    if ({busy, done_cnt} !== {1'b0, 32'd1}) begin
      mismatched++;
      $display("FAIL ignore_no_restart got busy=%b pulses=%0d want 0 1", busy, done_cnt);
    end
  endtask

  task automatic test_back_to_back;
    bit ok1, ok2;
    out_ready = 1;
    clear_log();
    pulse_start();
    wait_done(4000, ok1);
    clear_log();
    @(posedge clk);
    #1 start = 1;
    s_cyc = cyc;
    @(posedge clk);
    #1 start = 0;
    wait_done(4000, ok2);
    check_run("b2b", ok1 && ok2);
    compared++;
    if (first_rd != s_cyc + 1) begin mismatched++; $display("FAIL b2b_restart_latency got %0d want %0d", first_rd - s_cyc, 1); end
  endtask

  task automatic test_reset_mid;
    bit ok;
    int n_acc;
    out_ready = 1;
    clear_log();
    pulse_start();
    for (int i = 0; i < 1000 && acc_q.size() < 500; i++) nclk();
    n_acc = acc_q.size();
    #1 rst = 0;
    #1;
    compared++;
    if ({rd_en, rd_c, rd_addr, out_valid, out_data, out_chan, out_last, busy, done} !== '0) begin
      mismatched++;
      $display("FAIL rstmid_outputs got %b want all zero", {rd_en, rd_c, rd_addr, out_valid, out_data, out_chan, out_last, busy, done});
    end
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1;
    repeat (5) nclk();
    compared++;
    if (acc_q.size() != n_acc || out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL rstmid_flush got %0d outputs valid=%b want %0d valid=0", acc_q.size(), out_valid, n_acc);
    end
    compared++;
    if ({busy, done_cnt} !== {1'b0, 32'd0}) begin
      mismatched++;
      $display("FAIL rstmid_no_done got busy=%b pulses=%0d want 0 0", busy, done_cnt);
    end
    clear_log();
    pulse_start();
    wait_done(4000, ok);
    check_run("rstmid_replay", ok);
  endtask

  initial begin
    build_model();
    test_reset();
    test_order();
    test_backpressure();
    test_start_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
